// File: rtl/proj_kmer_window_if.sv
// Stream bundle around the k-mer window: base input channel and k-mer output channel.
// The slave modport is the window block; the master modport is the environment
// that supplies bases and consumes k-mers.
interface proj_kmer_window_if #(
  parameter int DATA_BITS = 2,
  parameter int KMER_LEN  = 4,
  parameter int POS_BITS  = 32
);
  // base input channel
  logic                                 in_valid;
  logic [DATA_BITS-1:0]                 in_data;
  logic                                 in_amb;
  logic                                 in_ready;
  // k-mer output channel
  logic                                 out_valid;
  logic                                 out_ready;
  logic [KMER_LEN-1:0][DATA_BITS-1:0]   out_kmer;
  logic                                 out_is_rc;
  logic [POS_BITS-1:0]                  out_pos;

  modport slave (
    input  in_valid, in_data, in_amb, out_ready,
    output in_ready, out_valid, out_kmer, out_is_rc, out_pos
  );

  modport master (
    output in_valid, in_data, in_amb, out_ready,
    input  in_ready, out_valid, out_kmer, out_is_rc, out_pos
  );
endinterface

// File: rtl/proj_kmer_window.sv
// Sliding k-mer window over a nucleotide stream. Ambiguous bases restart the
// window; every complete window is presented on a single registered output
// stage, either as the forward k-mer or as its canonical form.
package proj_pkg;
  localparam int KMER_BUFFER_BITS = 2;
  localparam int KMER_BUFFER_LEN  = 4;
endpackage

module proj_kmer_window #(
  parameter  int DATA_BITS = proj_pkg::KMER_BUFFER_BITS,
  parameter  int KMER_LEN  = proj_pkg::KMER_BUFFER_LEN,
  parameter  int POS_BITS  = 32,
  localparam int OUT_KMER  = KMER_LEN * DATA_BITS,
  localparam int FILL_BITS = $clog2(KMER_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_over,
  input  logic                 canon_en,
  proj_kmer_window_if.slave    bus,
  output logic [FILL_BITS-1:0] fill_cnt
);

  typedef logic [KMER_LEN-1:0][DATA_BITS-1:0] kmer_t;

  localparam logic [FILL_BITS-1:0] FILL_FULL = FILL_BITS'(KMER_LEN);
  // Complement-by-inversion only makes sense for the 2-bit A/C/G/T code.
  localparam bit CANON_OK = (DATA_BITS == 2);

  kmer_t                window_reg;
  logic [FILL_BITS-1:0] fill_reg;
  logic [POS_BITS-1:0]  pos_reg;
  logic                 out_valid_reg;
  kmer_t                out_kmer_reg;
  logic                 out_is_rc_reg;
  logic [POS_BITS-1:0]  out_pos_reg;

  logic                 in_ready_w;
  logic                 acc;
  logic                 emit;
  kmer_t                window_shift;
  kmer_t                rc_next;
  logic [FILL_BITS-1:0] fill_inc;
  logic [OUT_KMER-1:0]  fwd_flat;
  logic [OUT_KMER-1:0]  rc_flat;
  logic                 use_rc;
  kmer_t                sel_kmer;

  // Single output stage without skid buffer: a base is taken only when the
  // output register is free or being drained this cycle.
  assign in_ready_w = !start_over && (!out_valid_reg || bus.out_ready);
  assign acc        = bus.in_valid && in_ready_w;

  // Newest base enters at index 0; the oldest falls off the top.
  assign window_shift = {window_reg[KMER_LEN-2:0], bus.in_data};
  assign fill_inc     = (fill_reg == FILL_FULL) ? FILL_FULL : fill_reg + 1'b1;
  assign emit         = acc && !bus.in_amb && (fill_inc == FILL_FULL);

  // Reverse complement of the post-shift window: reversed order, each base inverted.
  generate
    for (genvar gi = 0; gi < KMER_LEN; gi++) begin : g_rc
      assign rc_next[gi] = ~window_shift[KMER_LEN-1-gi];
    end
  endgenerate

  assign fwd_flat = window_shift;
  assign rc_flat  = rc_next;

  // Canonical choice: strictly smaller reverse complement wins; ties keep forward.
  always_comb begin
    use_rc   = 1'b0;
    sel_kmer = window_shift;
    if (CANON_OK && canon_en && (rc_flat < fwd_flat)) begin
      use_rc   = 1'b1;
      sel_kmer = rc_next;
    end
  end

  // Window, fill/position counters and the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_reg    <= '0;
      fill_reg      <= '0;
      pos_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_kmer_reg  <= '0;
      out_is_rc_reg <= 1'b0;
      out_pos_reg   <= '0;
    end else if (start_over) begin
      // Restart discards any pending k-mer and begins a new sequence at position 0.
      window_reg    <= '0;
      fill_reg      <= '0;
      pos_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (acc) begin
        if (bus.in_amb) begin
          window_reg <= '0;
          fill_reg   <= '0;
        end else begin
          window_reg <= window_shift;
          fill_reg   <= fill_inc;
        end
        pos_reg <= pos_reg + POS_BITS'(1);
      end
      if (emit) begin
        out_valid_reg <= 1'b1;
        out_kmer_reg  <= sel_kmer;
        out_is_rc_reg <= use_rc;
        out_pos_reg   <= pos_reg;
      end else if (bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_kmer  = out_kmer_reg;
  assign bus.out_is_rc = out_is_rc_reg;
  assign bus.out_pos   = out_pos_reg;
  assign fill_cnt      = fill_reg;

endmodule

// File: tb/tb_proj_kmer_window.sv
// Directed bench for proj_kmer_window with KMER_LEN=4, DATA_BITS=2.
module tb_proj_kmer_window;

  localparam int DB = 2;
  localparam int KL = 4;
  localparam int PB = 32;

  localparam logic [1:0] A = 2'd0, C = 2'd1, G = 2'd2, T = 2'd3;

  typedef struct {
    logic        canon;
    logic        vld;
    logic        amb;
    logic [1:0]  data;
    logic        ordy;
    logic        exp_rdy;
    logic        exp_ov;
    logic [7:0]  exp_kmer;
    logic        exp_rc;
    logic [31:0] exp_pos;
    logic [2:0]  exp_fill;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_over = 1'b0;
  logic       canon_en = 1'b0;
  logic [2:0] fill_cnt;

  int checks = 0;
  int errors = 0;

  proj_kmer_window_if #(.DATA_BITS(DB), .KMER_LEN(KL), .POS_BITS(PB)) bus ();

  proj_kmer_window #(.DATA_BITS(DB), .KMER_LEN(KL), .POS_BITS(PB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_over (start_over),
    .canon_en   (canon_en),
    .bus        (bus),
    .fill_cnt   (fill_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic canon, input logic vld, input logic amb,
                              input logic [1:0] data, input logic ordy, input logic exp_rdy,
                              input logic exp_ov, input logic [7:0] exp_kmer, input logic exp_rc,
                              input logic [31:0] exp_pos, input logic [2:0] exp_fill);
    vec_t v;
    v.canon = canon; v.vld = vld; v.amb = amb; v.data = data; v.ordy = ordy;
    v.exp_rdy = exp_rdy; v.exp_ov = exp_ov; v.exp_kmer = exp_kmer; v.exp_rc = exp_rc;
    v.exp_pos = exp_pos; v.exp_fill = exp_fill;
    return v;
  endfunction

  // Drive one cycle of inputs, check the combinational ready, then the registered result.
  task automatic apply(input vec_t v, input string tag);
    canon_en      = v.canon;
    bus.in_valid  = v.vld;
    bus.in_amb    = v.amb;
    bus.in_data   = v.data;
    bus.out_ready = v.ordy;
    #1;
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'(v.exp_rdy));
    @(posedge clk);
    #1;
    $display("%s: vld=%0b amb=%0b data=%0d ordy=%0b -> ov=%0b kmer=%h rc=%0b pos=%0d fill=%0d",
             tag, v.vld, v.amb, v.data, v.ordy, bus.out_valid, bus.out_kmer, bus.out_is_rc,
             bus.out_pos, fill_cnt);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(v.exp_ov));
    chk({tag, " fill_cnt"}, 32'(fill_cnt), 32'(v.exp_fill));
    if (v.exp_ov) begin
      chk({tag, " out_kmer"}, 32'(bus.out_kmer), 32'(v.exp_kmer));
      chk({tag, " out_is_rc"}, 32'(bus.out_is_rc), 32'(v.exp_rc));
      chk({tag, " out_pos"}, bus.out_pos, v.exp_pos);
    end
  endtask

  vec_t vecs[$];
  vec_t seq[$];

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_amb    = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    //            canon vld amb data ordy | rdy ov kmer   rc pos fill
    // fill, forward
    vecs.push_back(mk(0, 1, 0, A, 1, 1, 0, 8'h00, 0, 0,  1));
    vecs.push_back(mk(0, 1, 0, A, 1, 1, 0, 8'h00, 0, 0,  2));
    vecs.push_back(mk(0, 1, 0, A, 1, 1, 0, 8'h00, 0, 0,  3));
    vecs.push_back(mk(0, 1, 0, C, 1, 1, 1, 8'h01, 0, 3,  4));
    // sliding, back-to-back
    vecs.push_back(mk(0, 1, 0, G, 1, 1, 1, 8'h06, 0, 4,  4));
    vecs.push_back(mk(0, 1, 0, T, 1, 1, 1, 8'h1B, 0, 5,  4));
    // canonical where forward (C,G,T,A) is already smaller
    vecs.push_back(mk(1, 1, 0, A, 1, 1, 1, 8'h6C, 0, 6,  4));
    // idle cycle drains the output
    vecs.push_back(mk(0, 0, 0, A, 1, 1, 0, 8'h00, 0, 0,  4));
    // N (data ignored) restarts the window, position still advances
    vecs.push_back(mk(1, 1, 1, T, 1, 1, 0, 8'h00, 0, 0,  0));
    // G,T,T,T canonical -> reverse complement A,A,A,C
    vecs.push_back(mk(1, 1, 0, G, 1, 1, 0, 8'h00, 0, 0,  1));
    vecs.push_back(mk(1, 1, 0, T, 1, 1, 0, 8'h00, 0, 0,  2));
    vecs.push_back(mk(1, 1, 0, T, 1, 1, 0, 8'h00, 0, 0,  3));
    vecs.push_back(mk(1, 1, 0, T, 1, 1, 1, 8'h01, 1, 11, 4));
    // palindrome A,C,G,T -> tie keeps forward
    vecs.push_back(mk(1, 1, 1, A, 1, 1, 0, 8'h00, 0, 0,  0));
    vecs.push_back(mk(1, 1, 0, A, 1, 1, 0, 8'h00, 0, 0,  1));
    vecs.push_back(mk(1, 1, 0, C, 1, 1, 0, 8'h00, 0, 0,  2));
    vecs.push_back(mk(1, 1, 0, G, 1, 1, 0, 8'h00, 0, 0,  3));
    vecs.push_back(mk(1, 1, 0, T, 1, 1, 1, 8'h1B, 0, 16, 4));
    // A,C,N,G,T,A,C
    vecs.push_back(mk(0, 1, 0, A, 1, 1, 1, 8'h6C, 0, 17, 4));
    vecs.push_back(mk(0, 1, 0, C, 1, 1, 1, 8'hB1, 0, 18, 4));
    vecs.push_back(mk(0, 1, 1, A, 1, 1, 0, 8'h00, 0, 0,  0));
    vecs.push_back(mk(0, 1, 0, G, 1, 1, 0, 8'h00, 0, 0,  1));
    vecs.push_back(mk(0, 1, 0, T, 1, 1, 0, 8'h00, 0, 0,  2));
    vecs.push_back(mk(0, 1, 0, A, 1, 1, 0, 8'h00, 0, 0,  3));
    vecs.push_back(mk(0, 1, 0, C, 1, 1, 1, 8'hB1, 0, 23, 4));
    // in_amb ignored without in_valid
    vecs.push_back(mk(0, 0, 1, T, 1, 1, 0, 8'h00, 0, 0,  4));
    // backpressure: emit with out_ready low, then hold for 5 cycles
    vecs.push_back(mk(0, 1, 0, G, 0, 1, 1, 8'hC6, 0, 24, 4));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(i[0], 1, 0, T, 0, 0, 1, 8'hC6, 0, 24, 4));
    // release: held k-mer consumed and next base accepted in the same cycle
    vecs.push_back(mk(0, 1, 0, T, 1, 1, 1, 8'h1B, 0, 25, 4));

    // reset state
    #2;
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset out_kmer", 32'(bus.out_kmer), 32'd0);
    chk("reset out_pos", bus.out_pos, 32'd0);
    chk("reset fill_cnt", 32'(fill_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("vec %0d", i));

    // start_over while a k-mer is held: discards it and blocks the presented base
    start_over    = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_amb    = 1'b0;
    bus.in_data   = G;
    bus.out_ready = 1'b0;
    #1;
    chk("start_over in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    $display("start_over: ov=%0b fill=%0d", bus.out_valid, fill_cnt);
    chk("start_over out_valid", 32'(bus.out_valid), 32'd0);
    chk("start_over fill_cnt", 32'(fill_cnt), 32'd0);
    start_over = 1'b0;

    // new sequence from position 0, canonical G,T,T,T
    seq.push_back(mk(1, 1, 0, G, 1, 1, 0, 8'h00, 0, 0, 1));
    seq.push_back(mk(1, 1, 0, T, 1, 1, 0, 8'h00, 0, 0, 2));
    seq.push_back(mk(1, 1, 0, T, 1, 1, 0, 8'h00, 0, 0, 3));
    seq.push_back(mk(1, 1, 0, T, 0, 1, 1, 8'h01, 1, 3, 4));
    for (int i = 0; i < seq.size(); i++)
      apply(seq[i], $sformatf("restart %0d", i));

    // asynchronous reset mid-stream, away from the clock edge
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: ov=%0b kmer=%h rc=%0b pos=%0d fill=%0d",
             bus.out_valid, bus.out_kmer, bus.out_is_rc, bus.out_pos, fill_cnt);
    chk("async reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("async reset out_kmer", 32'(bus.out_kmer), 32'd0);
    chk("async reset out_is_rc", 32'(bus.out_is_rc), 32'd0);
    chk("async reset out_pos", bus.out_pos, 32'd0);
    chk("async reset fill_cnt", 32'(fill_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // after release a full fresh window is needed before the first k-mer
    seq.delete();
    seq.push_back(mk(0, 1, 0, A, 1, 1, 0, 8'h00, 0, 0, 1));
    seq.push_back(mk(0, 1, 0, C, 1, 1, 0, 8'h00, 0, 0, 2));
    seq.push_back(mk(0, 1, 0, G, 1, 1, 0, 8'h00, 0, 0, 3));
    seq.push_back(mk(0, 1, 0, T, 1, 1, 1, 8'h1B, 0, 3, 4));
    seq.push_back(mk(0, 0, 0, A, 1, 1, 0, 8'h00, 0, 0, 4));
    for (int i = 0; i < seq.size(); i++)
      apply(seq[i], $sformatf("post-reset %0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/proj_kmer_window.md
Name: proj_kmer_window

Overview:
Parametrised successor to the project k-mer shift buffer. It accepts a nucleotide stream under valid/ready handshake and maintains a sliding window of KMER_LEN bases. Ambiguous bases restart the window. Every complete window is emitted through a registered, back-pressurable output stage, in forward form or in canonical form (the lesser of forward and reverse complement), together with the window's sequence position. It sits between the sequence reader and the MinHash hashing stage.

Parameters:
DATA_BITS, proj_pkg::KMER_BUFFER_BITS, bits per nucleotide; canonical mode is legal only when DATA_BITS==2 (A=0, C=1, G=2, T=3; complement = bitwise NOT)
KMER_LEN, proj_pkg::KMER_BUFFER_LEN, window length in bases, >=2
POS_BITS, 32, width of the sequence position counter
OUT_KMER, KMER_LEN*DATA_BITS, total output bits (derived; do not override)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_over  in  1  synchronous restart for a new sequence
canon_en  in  1  1 = emit canonical k-mer, 0 = emit forward k-mer
in_valid  in  1  input base valid
in_data  in  DATA_BITS  input base
in_amb  in  1  input base is ambiguous (N)
in_ready  out  1  block can accept a base this cycle
out_valid  out  1  output k-mer valid
out_ready  in  1  consumer accepts the output
out_kmer  out  [KMER_LEN-1:0][DATA_BITS-1:0]  k-mer; index 0 = newest base
out_is_rc  out  1  out_kmer is the reverse complement
out_pos  out  POS_BITS  position (from 0) of the newest base in out_kmer
fill_cnt  out  $clog2(KMER_LEN+1)  number of valid bases currently in the window

Behaviour:
- One clock domain. Reset is asynchronous and active-low on rst_n.
- Reset values: window = 0, fill_cnt = 0, pos = 0, out_valid = 0, out_kmer = 0, out_is_rc = 0, out_pos = 0.
- Ready rule: in_ready = !start_over && (!out_valid || out_ready). This is combinational and forms a single output stage with no skid buffer.
- Accept condition: acc = in_valid && in_ready.
- Valid base accepted:
  - window shifts: new[0] = in_data, new[i] = old[i-1];
  - fill_cnt increments, saturating at KMER_LEN (fixes the KMER_LEN-1 saturation of the previous buffer);
  - pos increments, wrapping at 2^POS_BITS.
- Ambiguous base accepted: window is cleared to 0, fill_cnt = 0, pos still increments, no output is produced.
- Emit condition: an accepted non-ambiguous base makes the post-update fill_cnt equal KMER_LEN. The next cycle then has out_valid = 1 and loads out_kmer, out_is_rc and out_pos (= pos of that base). Latency is 1 cycle from acceptance.
- Output hold: while out_valid && !out_ready, all out_* stay stable and in_ready = 0.
- Output clear: out_valid drops the cycle after an out_ready handshake unless a new emit occurs in that same cycle. A simultaneous handshake and emit replaces the output without a bubble.
- Reverse complement: rc[i] = ~fwd[KMER_LEN-1-i].
- Canonical selection:
  - when canon_en = 1, compare fwd and rc as unsigned OUT_KMER-bit packed vectors (index KMER_LEN-1 is the MSB);
  - emit the smaller with out_is_rc = 1 if rc was chosen; a tie emits fwd with out_is_rc = 0;
  - canon_en is sampled in the accept cycle;
  - when canon_en = 0, output fwd with out_is_rc = 0.
- start_over: synchronous. Clears window, fill_cnt, pos and out_valid, discarding any pending output. It has priority over in_valid (no base is accepted that cycle) and over out_ready.
- Reset mid-stream: asynchronous clear to the reset values. The first emit after release requires KMER_LEN fresh bases.
- in_data is ignored when in_amb = 1. in_amb and in_data are ignored when in_valid = 0.

Test Plan:
- Fill: KMER_LEN=4, canon_en=0, bases A,A,A,C (positions 0..3), out_ready=1 -> no out_valid during the first 3 accepts; the cycle after the 4th accept, out_valid=1, out_kmer packed=8'h01, out_pos=3, out_is_rc=0; fill_cnt saturates at 4.
- Canonical: canon_en=1, bases G,T,T,T -> forward 8'hBF, output out_kmer=8'h01, out_is_rc=1. Palindrome A,C,G,T -> 8'h1B, out_is_rc=0 (tie).
- Sliding: continue after the Fill scenario with G -> out_kmer=8'h06 (A,A,C,G), out_pos=4. One output per base, back-to-back, no bubbles with out_ready held at 1.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 and out_* stable throughout. Raise out_ready -> the held k-mer is consumed, the next base is accepted in the same cycle, and its k-mer appears the following cycle.
- Ambiguous: A,C,N,G,T,A,C -> no output until the 4th base after N; first output is G,T,A,C = 8'hB1 with out_pos=6; fill_cnt reads 0 right after N.
- start_over/reset: assert start_over with out_valid=1 and out_ready=0 -> next cycle out_valid=0, fill_cnt=0, pos restarts at 0, the base presented that cycle is not accepted. Pulse rst_n low mid-stream -> outputs go to reset values immediately.
